// File: rtl/state_dump_unit.sv
// state_dump_unit
//   Reads back processor state through combinational read ports: all
//   NUM_REGS registers first, then a programmed window of data memory.
//   Each word is streamed as one beat on a valid/ready port.
//
//   Ports
//     clk1, reset                 clock, synchronous active-high reset
//     start                       dump request (honoured only when idle)
//     mem_base, mem_len           memory window, captured on accepted start
//     reg_rd_addr / reg_rd_data   register file read port (comb data)
//     mem_rd_addr / mem_rd_data   data memory read port (comb data)
//     out_valid / out_ready       beat handshake
//     out_data, out_src, out_idx  beat payload (src 00 reg, 01 mem, 11 csum)
//     out_last                    final beat of the dump
//     busy, done                  dump in flight / one-cycle completion pulse
//
//   Optional macro DUMP_CHECKSUM_EN: appends one XOR-checksum beat
//   {xor of all data beats, src 11, idx 0} that alone carries out_last.
module state_dump_unit #(
  parameter int DATA_W = 9,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 4
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic [MEM_AW-1:0] mem_base,
  input  logic [MEM_AW:0]   mem_len,
  output logic [REG_AW-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic [MEM_AW-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int NUM_REGS = 2**REG_AW;

`ifdef DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REG, MEM, FIN} state_t;

  state_t            state;
  logic [MEM_AW-1:0] cnt;
  logic [MEM_AW-1:0] base_q;
  logic [MEM_AW:0]   len_q;

  logic load, accept, reg_end, mem_end;

  // Output register may take a new beat when empty or being drained.
  assign load    = !out_valid || out_ready;
  assign accept  = out_valid && out_ready;
  assign reg_end = (cnt == MEM_AW'(NUM_REGS-1));
  assign mem_end = ({1'b0, cnt} == len_q - 1'b1);

  // Read addresses follow the counter directly so the combinational data
  // is ready to be captured on the same edge that advances the counter.
  assign reg_rd_addr = cnt[REG_AW-1:0];
  assign mem_rd_addr = base_q + cnt;   // wraps modulo 2**MEM_AW

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
`endif

  always_ff @(posedge clk1) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      base_q    <= '0;
      len_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'b00;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      // Fold every data beat as the consumer takes it.
      if (accept && out_src != 2'b11) acc <= acc ^ out_data;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= mem_base;
            len_q  <= mem_len;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= REG;
`ifdef DUMP_CHECKSUM_EN
            acc    <= '0;
`endif
          end
        end
        REG: begin
          if (load) begin
            out_valid <= 1'b1;
            out_data  <= reg_rd_data;
            out_src   <= 2'b00;
            out_idx   <= MEM_AW'(reg_rd_addr);
            out_last  <= 1'b0;
            if (reg_end) begin
              if (len_q == '0) begin
                out_last <= !CSUM;
                state    <= FIN;
              end else begin
                cnt   <= '0;
                state <= MEM;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        MEM: begin
          if (load) begin
            out_valid <= 1'b1;
            out_data  <= mem_rd_data;
            out_src   <= 2'b01;
            out_idx   <= mem_rd_addr;
            out_last  <= 1'b0;
            if (mem_end) begin
              out_last <= !CSUM;
              state    <= FIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FIN: begin
          if (accept) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
`ifdef DUMP_CHECKSUM_EN
            else begin
              // Last data beat is leaving now; include it in the checksum.
              out_data <= acc ^ out_data;
              out_src  <= 2'b11;
              out_idx  <= '0;
              out_last <= 1'b1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/state_dump_unit.md
Name: state_dump_unit

Overview:
- Reader-side companion to the processor's register file and data memory.
- On a dump request, it walks every register, then a programmed window of memory, using combinational read ports.
- Each word is streamed out on a valid/ready interface with a source tag, an index and a last flag.
- Gives the bench and debug logic a hardware path to read back processor state, instead of hierarchical peeks.

Parameters:
- DATA_W, 9, width of register and memory words.
- REG_AW, 4, register index width; NUM_REGS = 2**REG_AW = 16.
- MEM_AW, 4, memory address width; must be >= REG_AW.

Ports:
- clk1  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle dump request; sampled only in IDLE.
- mem_base  input  MEM_AW  first memory address to dump; captured on accepted start.
- mem_len  input  MEM_AW+1  number of memory words to dump (0..2**MEM_AW); captured on accepted start.
- reg_rd_addr  output  REG_AW  register read address.
- reg_rd_data  input  DATA_W  register data, combinational from reg_rd_addr.
- mem_rd_addr  output  MEM_AW  memory read address.
- mem_rd_data  input  DATA_W  memory data, combinational from mem_rd_addr.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready at the clock edge.
- out_data  output  DATA_W  word value.
- out_src  output  2  00 = register, 01 = memory, 11 = checksum.
- out_idx  output  MEM_AW  register index (zero-extended) or memory address.
- out_last  output  1  final beat of the dump.
- busy  output  1  high from the accepted start until the last beat is accepted.
- done  output  1  one-cycle pulse in the cycle after the last beat is accepted.

Behaviour:
- Reset values:
  - out_valid = 0, busy = 0, done = 0, out_last = 0.
  - out_data = 0, out_src = 0, out_idx = 0.
  - reg_rd_addr = 0, mem_rd_addr = 0.
  - FSM enters IDLE.
- FSM states: IDLE, REG, MEM, FIN.
- IDLE:
  - On start: capture mem_base and mem_len, clear the index counter, set busy, go to REG.
  - start while busy is ignored; no queueing.
- REG:
  - reg_rd_addr = counter.
  - The output register is loaded with {reg_rd_data, src 00, idx counter} when it is empty or its beat is being accepted.
  - Beats come out one cycle after the address is issued.
  - Exit after index NUM_REGS-1 has been loaded:
    - mem_len = 0: that register beat carries out_last; go to FIN.
    - Otherwise: go to MEM with the counter cleared.
- MEM:
  - mem_rd_addr = (mem_base + counter) mod 2**MEM_AW; the address wraps past the top.
  - Beat is {mem_rd_data, src 01, idx = mem_rd_addr}.
  - The beat with counter = mem_len-1 carries out_last; go to FIN.
- FIN: wait until the last beat is accepted, then pulse done, drop busy, go to IDLE.
- Handshake rules:
  - While out_valid && !out_ready, out_data, out_src, out_idx and out_last hold stable and the counter does not advance.
  - With out_ready held high, throughput is 1 beat per clock; total beats = 16 + mem_len.
- Latency: the first beat appears (out_valid = 1) 2 cycles after the cycle in which start is sampled.
- reset mid-dump: next cycle all outputs are at reset values and the FSM is in IDLE; the partial dump is abandoned with no last beat and no done.
- The same-cycle start and reset combination resolves to reset.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- When defined:
  - A DATA_W-bit XOR accumulator clears on the accepted start.
  - It folds in every accepted data beat.
  - After the final data beat, one extra beat {accumulator, src 11, idx 0} is emitted; only that beat carries out_last.
  - Beat count = 17 + mem_len.
- When undefined: no accumulator and no extra beat; out_src never equals 11.

Test Plan:
- Reg[k] = k, Mem[a] = a+100, mem_base = 0, mem_len = 8, out_ready = 1.
  - -> 24 consecutive beats: R0..R15 data 0..15 src 00, then Mem0..7 data 100..107 src 01.
  - -> out_last on beat 24; done one cycle after beat 24; busy low after done.
- Same setup with out_ready toggling 1-0-0-1.
  - -> every stalled beat holds identical data/src/idx; no beat lost or duplicated; order unchanged.
- mem_base = 14, mem_len = 4.
  - -> memory beats at idx 14, 15, 0, 1 with data 114, 115, 100, 101; last on the idx-1 beat.
- mem_len = 0.
  - -> exactly 16 beats, out_last on R15; start pulses during busy produce no second dump.
- reset asserted on beat 5 with out_ready = 1.
  - -> next cycle out_valid = 0, busy = 0, no done; a subsequent start gives a full, correct dump.
- DUMP_CHECKSUM_EN defined, Reg[k] = k, mem_len = 0.
  - -> 17 beats; final beat src 11, data 0 (XOR of 0..15), out_last = 1.
